// File: rtl/fir_tap_sequencer_if.sv
// Start/ready/busy handshake between the FIR tap sequencer and multiplier_fp.
// master = sequencer side, slave = multiplier side.
interface fir_tap_sequencer_if;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_ready;
   logic        mul_busy;
   logic [31:0] mul_y;

   modport master (
      output mul_start, mul_a, mul_b,
      input  mul_ready, mul_busy, mul_y
   );

   modport slave (
      input  mul_start, mul_a, mul_b,
      output mul_ready, mul_busy, mul_y
   );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: fp32 delay line plus coefficient file.
// Issues one x[n-i]*c[i] per tap to multiplier_fp and streams the products.
module fir_tap_sequencer #(
   parameter int N_TAPS  = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coef_we,
   input  logic [IDX_W-1:0]    coef_addr,
   input  logic [31:0]         coef_wdata,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_data,
   fir_tap_sequencer_if.master mif,
   output logic                prod_valid,
   output logic [31:0]         prod_data,
   output logic [IDX_W-1:0]    prod_idx,
   output logic                prod_last,
   output logic                seq_busy,
   output logic                err_timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    T_MAX = TW'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_TAPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t           state;
   logic [31:0]      d    [N_TAPS];
   logic [31:0]      coef [N_TAPS];
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] nxt;
   logic [TW-1:0]    timer;
   logic [31:0]      mul_a;
   logic [31:0]      mul_b;

   assign nxt = idx + 1'b1;

   // Start fires in the ISSUE cycle itself so a tap costs 1 + L cycles.
   assign mif.mul_start = (state == ISSUE) && !mif.mul_busy;
   assign mif.mul_a     = mul_a;
   assign mif.mul_b     = mul_b;

   assign in_ready = rst_n && (state == IDLE);
   assign seq_busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         timer       <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         prod_valid  <= 1'b0;
         prod_data   <= '0;
         prod_idx    <= '0;
         prod_last   <= 1'b0;
         err_timeout <= 1'b0;
         for (int i = 0; i < N_TAPS; i++) begin
            d[i]    <= '0;
            coef[i] <= '0;
         end
      end else begin
         prod_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (coef_we)
                  coef[coef_addr] <= coef_wdata;
               if (in_valid) begin
                  d[0] <= in_data;
                  for (int i = 1; i < N_TAPS; i++)
                     d[i] <= d[i-1];
                  idx   <= '0;
                  mul_a <= in_data;
                  // A same-cycle write to coef[0] must reach tap 0.
                  mul_b <= (coef_we && coef_addr == '0) ?
                           coef_wdata : coef[0];
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!mif.mul_busy) begin
                  timer <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (mif.mul_ready) begin
                  prod_valid <= 1'b1;
                  prod_data  <= mif.mul_y;
                  prod_idx   <= idx;
                  prod_last  <= (idx == LAST);
                  if (idx == LAST) begin
                     state <= IDLE;
                  end else begin
                     idx   <= nxt;
                     mul_a <= d[nxt];
                     mul_b <= coef[nxt];
                     state <= ISSUE;
                  end
               end else if (timer == T_MAX) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
